// File: rtl/add_seq_ctrl.sv
// Multi-cycle wide adder: one CHUNK-bit Kogge-Stone slice per clock, carry chained through a register.
// Optional subtract support is enabled by defining ADD_SEQ_SUB_EN.
module add_seq_ctrl #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADD_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NChunk = WIDTH / CHUNK;
    localparam int unsigned IdxW   = (NChunk > 1) ? $clog2(NChunk) : 1;
    localparam int unsigned Levels = $clog2(CHUNK);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NChunk - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [IdxW-1:0]  idx_q, idx_d;

    logic [CHUNK-1:0] slice_a, slice_b, slice_p, slice_sum;
    logic [CHUNK:0]   cvec;
    logic             accept;

    // Prefix network; the registered carry is folded into bit 0 generate so
    // the prefix output at bit i is the carry out of bit i.
    always_comb begin : prefix
        logic [CHUNK-1:0] g;
        logic [CHUNK-1:0] p;
        slice_a = a_q[int'(idx_q) * CHUNK +: CHUNK];
        slice_b = b_q[int'(idx_q) * CHUNK +: CHUNK];
        slice_p = slice_a ^ slice_b;
        p       = slice_p;
        g       = (slice_a & slice_b) | CHUNK'(slice_p[0] & carry_q);
        for (int l = 0; l < int'(Levels); l++) begin
            g = g | (p & (g << (1 << l)));
            p = p & ((p << (1 << l)) | CHUNK'((1 << l) - 1));
        end
        cvec      = {g, carry_q};
        slice_sum = slice_p ^ cvec[CHUNK-1:0];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        accept  = start && (state_q != StRun);

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StRun;
            end
            StRun: begin
                sum_d[int'(idx_q) * CHUNK +: CHUNK] = slice_sum;
                carry_d = cvec[CHUNK];
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                    cout_d  = cvec[CHUNK];
                    ovf_d   = cvec[CHUNK] ^ cvec[CHUNK-1];
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                state_d = start ? StRun : StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            a_d   = a;
            idx_d = '0;
`ifdef ADD_SEQ_SUB_EN
            b_d     = sub ? ~b : b;
            carry_d = sub | cin;
`else
            b_d     = b;
            carry_d = cin;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: doc/add_seq_ctrl.md
# add_seq_ctrl

Multi-cycle sequencer for wide additions on a narrow parallel-prefix slice. A WIDTH-bit add is split into WIDTH/CHUNK slices. The block feeds one slice per clock through a CHUNK-bit prefix (P/G) network, registers the slice carry-out as the next slice's carry-in, and assembles the full sum. It sits between the adder datapath and any client that needs wide arithmetic without a full-width prefix tree.

## Interface
- WIDTH, 64, total operand width; must be an integer multiple of CHUNK.
- CHUNK, 16, slice width processed per cycle; NCHUNK = WIDTH/CHUNK (≥1).
- clk  in  1  rising-edge clock, sole clock domain.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  request a new addition; sampled on clk rising edge.
- a  in  WIDTH  operand A; sampled only when start is accepted.
- b  in  WIDTH  operand B; sampled only when start is accepted.
- cin  in  1  carry-in to slice 0; sampled only when start is accepted.
- busy  out  1  high while slices are being processed (RUN state).
- done  out  1  one-cycle pulse; sum/cout/ovf valid.
- sum  out  WIDTH  result; holds until the next completion.
- cout  out  1  carry-out of the top slice.
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN on start.
  - RUN stays until the slice index reaches NCHUNK-1, then →DONE.
  - DONE→RUN if start, else →IDLE.
- Start is accepted only in IDLE or DONE. Start during RUN is ignored and does not re-latch operands.
- On accept:
  - latch a, b (and sub) into operand registers;
  - carry register ← cin;
  - slice index ← 0.
- Each RUN cycle k:
  - slice bits [k*CHUNK +: CHUNK] form gi=a&b and pi=a^b;
  - a log2(CHUNK)-level Kogge-Stone prefix computes the internal carries, using the carry register as slice carry-in;
  - sum slice bits = pi ^ carries; result written into sum bits [k*CHUNK +: CHUNK];
  - carry register ← slice carry-out;
  - the carry into bit CHUNK-1 is saved for ovf on the final slice.
- On the final slice, cout ← slice carry-out and ovf ← carry-in(MSB) ^ carry-out(MSB), both registered at the same edge as the last sum slice.
- sum is built in place. Slices above the current index still hold the previous result while busy=1. Clients read sum only when done=1 or afterwards.

## Timing
- Reset (rst_n low at an edge) forces state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, index=0, carry register=0. This applies in any state, including mid-RUN; no done pulse follows an aborted operation.
- Start sampled at edge 0:
  - busy=1 from edge 0 to edge NCHUNK;
  - done=1 for exactly the cycle after edge NCHUNK;
  - latency = NCHUNK cycles.
- NCHUNK=1: a single RUN cycle, then DONE; latency is 1.
- Back-to-back: start high during DONE begins the next operation at that edge. done drops and busy rises together, giving a throughput of one operation per NCHUNK+1 cycles.
- Outputs are all registered; no combinational path from inputs to outputs.

## Configuration
- ADD_SEQ_SUB_EN defined:
  - adds port sub (in, 1), latched with the operands on start;
  - sub=1 computes a − b: operand B is stored inverted and slice-0 carry-in is forced to 1 (cin ignored);
  - cout=1 means no borrow; ovf uses the same rule.
- ADD_SEQ_SUB_EN undefined: no sub port; add only.

## Test plan
- WIDTH=64, CHUNK=16. Apply a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 → done exactly 4 cycles after start, sum=0, cout=1, ovf=0; the carry ripples through every slice.
- a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0 → sum=0x8000_0000_0000_0000, cout=0, ovf=1.
- Start with a=3, b=4, then pulse start with a=100, b=100 at RUN cycle 2 → single done, sum=7; the second request is ignored.
- Hold start high through DONE with new operands a=10, b=20, cin=1 → busy low for 0 cycles, second done 5 cycles after the first, sum=31.
- Drive rst_n low at RUN cycle 2 → next edge busy=0, sum=0, cout=0; no done pulse; a fresh start afterwards completes normally.
- ADD_SEQ_SUB_EN defined: a=5, b=7, sub=1 → sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Then a=7, b=5 → sum=2, cout=1.
